// File: rtl/buff_uart_frame_ctrl.sv
// rtl/buff_uart_frame_ctrl.sv - register-port master that polls buff_uart, parses RX frames and answers ACK/NAK
//
// Polls the UART status register and pops RX bytes one at a time into a frame
// parser. The frame format is: sync 0xA5, length, payload, checksum. The
// length, payload and checksum bytes must sum to 0 mod 256. Payload bytes are
// forwarded on a valid/ready stream. When a frame ends, an ACK (0x06) or NAK
// (0x15) byte is queued and written to the UART TX register.
//
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   active_address       register address presented with a strobe (0 otherwise)
//   read_enable          one-cycle read strobe; bus_rdata is valid the next cycle
//   write_enable         one-cycle write strobe carrying bus_wdata
//   bus_wdata            write data (ACK/NAK byte)
//   bus_rdata            read data returned by the UART
//   out_data/out_valid   payload byte stream, held until out_ready
//   out_ready            downstream accept
//   frame_done/frame_ok  one-cycle frame-end pulse, frame_ok = checksum good
//   busy                 parser is inside a frame
module buff_uart_frame_ctrl #(
  parameter int width          = 8,
  parameter int address_width  = 4,
  parameter int rx_address     = 3,
  parameter int tx_address     = 4,
  parameter int status_address = 5,
  parameter int max_len        = 32
) (
  input  logic                     clock,
  input  logic                     resetn,
  output logic [address_width-1:0] active_address,
  output logic                     read_enable,
  output logic                     write_enable,
  output logic [width-1:0]         bus_wdata,
  input  logic [width-1:0]         bus_rdata,
  output logic [width-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done,
  output logic                     frame_ok,
  output logic                     busy
);

  localparam logic [width-1:0]         sync_byte = width'(8'hA5);
  localparam logic [width-1:0]         ack_byte  = width'(8'h06);
  localparam logic [width-1:0]         nak_byte  = width'(8'h15);
  localparam logic [width-1:0]         len_limit = width'(max_len);
  localparam logic [address_width-1:0] rx_addr   = address_width'(rx_address);
  localparam logic [address_width-1:0] tx_addr   = address_width'(tx_address);
  localparam logic [address_width-1:0] stat_addr = address_width'(status_address);

  typedef enum logic [2:0] {
    BUS_POLL, BUS_STAT, BUS_POP, BUS_BYTE, BUS_WRITE
  } bus_state_t;

  typedef enum logic [1:0] {
    P_HUNT, P_LEN, P_PAYLOAD, P_CHK
  } parse_state_t;

  bus_state_t   bus_state, bus_next;
  parse_state_t parse_state, parse_next;

  // Holds off the first status read for one cycle so every bus output is
  // 0 while the block comes out of reset.
  logic             armed;
  logic             pending;
  logic             pending_ack;
  logic [width-1:0] remaining;
  logic [width-1:0] sum;
  logic [width-1:0] chk_total;
  logic             byte_step;

  assign byte_step = (bus_state == BUS_BYTE);
  assign chk_total = sum + bus_rdata;

  // State registers for both the bus FSM and the parser FSM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus_state   <= BUS_POLL;
      parse_state <= P_HUNT;
    end else begin
      bus_state   <= bus_next;
      parse_state <= parse_next;
    end
  end

  // Next-state logic.
  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      BUS_POLL:  if (armed) bus_next = BUS_STAT;
      BUS_STAT: begin
        // A queued response wins over RX, and no RX byte is taken while one
        // is queued, so a second response can never pile up behind it.
        if (pending && !bus_rdata[1])
          bus_next = BUS_WRITE;
        else if (bus_rdata[0] && !out_valid && !pending)
          bus_next = BUS_POP;
        else
          bus_next = BUS_POLL;
      end
      BUS_POP:   bus_next = BUS_BYTE;
      BUS_BYTE:  bus_next = BUS_POLL;
      BUS_WRITE: bus_next = BUS_POLL;
      default:   bus_next = BUS_POLL;
    endcase

    parse_next = parse_state;
    if (byte_step) begin
      case (parse_state)
        P_HUNT:    if (bus_rdata == sync_byte) parse_next = P_LEN;
        P_LEN: begin
          if (bus_rdata > len_limit)   parse_next = P_HUNT;
          else if (bus_rdata == '0)    parse_next = P_CHK;
          else                         parse_next = P_PAYLOAD;
        end
        P_PAYLOAD: if (remaining == width'(1)) parse_next = P_CHK;
        P_CHK:     parse_next = P_HUNT;
        default:   parse_next = P_HUNT;
      endcase
    end
  end

  // Bus strobes and status outputs.
  always_comb begin
    read_enable    = 1'b0;
    write_enable   = 1'b0;
    active_address = '0;
    bus_wdata      = '0;
    case (bus_state)
      BUS_POLL: begin
        read_enable    = armed;
        active_address = armed ? stat_addr : '0;
      end
      BUS_POP: begin
        read_enable    = 1'b1;
        active_address = rx_addr;
      end
      BUS_WRITE: begin
        write_enable   = 1'b1;
        active_address = tx_addr;
        bus_wdata      = pending_ack ? ack_byte : nak_byte;
      end
      default: ;
    endcase
    busy = (parse_state != P_HUNT);
  end

  // Parser datapath, payload stream and response bookkeeping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      armed       <= 1'b0;
      pending     <= 1'b0;
      pending_ack <= 1'b0;
      remaining   <= '0;
      sum         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
    end else begin
      armed      <= 1'b1;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (bus_state == BUS_WRITE) pending <= 1'b0;

      if (byte_step) begin
        case (parse_state)
          P_LEN: begin
            sum       <= bus_rdata;
            remaining <= bus_rdata;
            if (bus_rdata > len_limit) begin
              frame_done  <= 1'b1;
              pending     <= 1'b1;
              pending_ack <= 1'b0;
            end
          end
          P_PAYLOAD: begin
            // A pop is only issued with the stream empty, so this never
            // overwrites an unaccepted byte.
            out_data  <= bus_rdata;
            out_valid <= 1'b1;
            sum       <= sum + bus_rdata;
            remaining <= remaining - width'(1);
          end
          P_CHK: begin
            frame_done  <= 1'b1;
            frame_ok    <= (chk_total == '0);
            pending     <= 1'b1;
            pending_ack <= (chk_total == '0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buff_uart_frame_ctrl.sv
// tb/tb_buff_uart_frame_ctrl.sv - scoreboard bench for buff_uart_frame_ctrl with a UART register model
module tb_buff_uart_frame_ctrl;

  localparam int MAX_LEN = 32;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] active_address;
  logic       read_enable;
  logic       write_enable;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       frame_done;
  logic       frame_ok;
  logic       busy;

  buff_uart_frame_ctrl #(
    .width(8), .address_width(4), .rx_address(3), .tx_address(4),
    .status_address(5), .max_len(MAX_LEN)
  ) dut (
    .clock(clock), .resetn(resetn), .active_address(active_address),
    .read_enable(read_enable), .write_enable(write_enable),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .frame_ok(frame_ok), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [7:0] rx_q[$];
  logic       tx_full = 1'b0;
  logic [7:0] last_status = 8'h00;
  int         status_reads = 0;

  logic [7:0] exp_payload[$];
  logic       exp_ok[$];
  logic [7:0] exp_tx[$];
  logic       outstanding = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       rand_ready = 1'b0;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // UART register model: reads return data on the following cycle.
  always @(posedge clock) begin
    if (resetn && read_enable) begin
      if (active_address == 4'd5) begin
        bus_rdata    <= {6'b0, tx_full, rx_q.size() != 0};
        last_status  <= {6'b0, tx_full, rx_q.size() != 0};
        status_reads <= status_reads + 1;
      end else if (active_address == 4'd3) begin
        bus_rdata <= (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
      end else begin
        bus_rdata <= 8'hEE;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something.
  always @(negedge clock) begin
    if (!resetn) begin
      outstanding = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      check("strobe_exclusive", {31'd0, read_enable & write_enable}, 0);
      if (read_enable && active_address == 4'd3) begin
        check("rx_after_nonempty_status", {31'd0, last_status[0]}, 1);
        check("rx_while_out_valid", {31'd0, out_valid}, 0);
        check("rx_while_response_pending", {31'd0, outstanding}, 0);
      end
      if (write_enable) begin
        check("tx_address", {28'd0, active_address}, 4);
        check("tx_while_full", {31'd0, last_status[1]}, 0);
        if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, bus_wdata}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, bus_wdata}, {24'd0, exp_tx.pop_front()});
        outstanding = 1'b0;
      end
      if (prev_stall && out_valid)
        check("out_data_stable", {24'd0, out_data}, {24'd0, prev_data});
      if (out_valid && out_ready) begin
        if (exp_payload.size() == 0) check("payload_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
        else check("payload", {24'd0, out_data}, {24'd0, exp_payload.pop_front()});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (frame_done) begin
        if (exp_ok.size() == 0) check("frame_unexpected", {31'd0, frame_ok}, 32'hFFFF_FFFF);
        else check("frame_ok", {31'd0, frame_ok}, {31'd0, exp_ok.pop_front()});
        outstanding = 1'b1;
      end else begin
        check("frame_ok_without_done", {31'd0, frame_ok}, 0);
      end
    end
  end

  // Reference: scans a complete byte stream frame by frame.
  task automatic ref_model(input logic [7:0] s[$]);
    int i = 0;
    while (i < s.size()) begin
      int len;
      int total;
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= s.size()) break;
      len = int'(s[i+1]);
      if (len > MAX_LEN) begin
        exp_ok.push_back(1'b0);
        exp_tx.push_back(8'h15);
        i += 2;
        continue;
      end
      if (i + 2 + len >= s.size()) break;
      total = len;
      for (int k = 0; k < len; k++) begin
        exp_payload.push_back(s[i+2+k]);
        total += int'(s[i+2+k]);
      end
      total += int'(s[i+2+len]);
      exp_ok.push_back((total % 256) == 0);
      exp_tx.push_back(((total % 256) == 0) ? 8'h06 : 8'h15);
      i += len + 3;
    end
  endtask

  task automatic load(input logic [7:0] s[$]);
    foreach (s[k]) rx_q.push_back(s[k]);
    ref_model(s);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string name);
    int c;
    for (c = 0; c < 6000; c++) begin
      step();
      if (rx_q.size() == 0 && exp_payload.size() == 0 && exp_ok.size() == 0 &&
          exp_tx.size() == 0 && !outstanding && !out_valid) break;
    end
    if (c >= 6000) begin
      check({name, "_drain_timeout"}, 1, 0);
      exp_payload.delete();
      exp_ok.delete();
      exp_tx.delete();
    end
    repeat (4) step();
  endtask

  task automatic check_quiet(input string name);
    check({name, "_address"}, {28'd0, active_address}, 0);
    check({name, "_read_enable"}, {31'd0, read_enable}, 0);
    check({name, "_write_enable"}, {31'd0, write_enable}, 0);
    check({name, "_bus_wdata"}, {24'd0, bus_wdata}, 0);
    check({name, "_out_valid"}, {31'd0, out_valid}, 0);
    check({name, "_out_data"}, {24'd0, out_data}, 0);
    check({name, "_frame_done"}, {31'd0, frame_done}, 0);
    check({name, "_busy"}, {31'd0, busy}, 0);
  endtask

  logic [7:0] s[$];

  initial begin
    int n;
    int sr0;
    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset");
    resetn = 1'b1;
    out_ready = 1'b1;

    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    load(s); drain("good_frame");
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'hB8};
    load(s); drain("bad_checksum");
    s = '{8'h00, 8'h7F, 8'hA5, 8'h00, 8'h00};
    load(s); drain("zero_len");
    s = '{8'hA5, 8'h21, 8'hA5, 8'h01, 8'h44, 8'hBB};
    load(s); drain("too_long");

    // Backpressure: first payload byte held for 10 cycles with RX not empty.
    out_ready = 1'b0;
    s = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    load(s);
    for (n = 0; n < 500 && !out_valid; n++) step();
    check("stall_reached_valid", {31'd0, out_valid}, 1);
    sr0 = rx_q.size();
    repeat (10) step();
    check("stall_no_pop", sr0, rx_q.size());
    check("stall_data", {24'd0, out_data}, 32'h01);
    out_ready = 1'b1;
    drain("stall");

    // Response held back by tx_full; nothing more is popped meanwhile.
    tx_full = 1'b1;
    s = '{8'hA5, 8'h01, 8'h44, 8'hBB, 8'hA5, 8'h00, 8'h00};
    load(s);
    for (n = 0; n < 500 && !outstanding; n++) step();
    check("txfull_frame_seen", {31'd0, outstanding}, 1);
    sr0 = status_reads;
    for (n = 0; n < 200 && status_reads < sr0 + 5; n++) step();
    check("txfull_no_write", exp_tx.size(), 2);
    check("txfull_no_pop", rx_q.size(), 3);
    tx_full = 1'b0;
    drain("txfull");

    // Reset inside a frame: nothing is answered and parsing restarts at HUNT.
    s = '{8'hA5, 8'h05};
    foreach (s[k]) rx_q.push_back(s[k]);
    for (n = 0; n < 500 && rx_q.size() != 0; n++) step();
    repeat (8) step();
    check("midframe_busy", {31'd0, busy}, 1);
    resetn = 1'b0;
    #1;
    check_quiet("midframe_reset");
    step();
    resetn = 1'b1;
    s = '{8'h11, 8'hA5, 8'h02, 8'h80, 8'h7F, 8'h7F};
    load(s); drain("after_reset");

    // Randomized frames with junk, varied lengths and random backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      int len;
      logic [7:0] sum;
      s.delete();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j;
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        s.push_back(j);
      end
      len = $urandom_range(0, 36);
      s.push_back(8'hA5);
      s.push_back(8'(len));
      if (len <= MAX_LEN) begin
        sum = 8'(len);
        for (int k = 0; k < len; k++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          s.push_back(b);
          sum = sum + b;
        end
        s.push_back(8'(8'd0 - sum) + 8'($urandom_range(0, 1)));
      end
      load(s);
      drain("random");
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
